// File: rtl/fifo_mac_reader_if.sv
// fifo_mac_reader_if: FIFO read port and block-result valid/ready port.
// slave: reader side (n_empty, Dout, out_ready in; RE, acc_out, out_valid, ovf, busy out).
interface fifo_mac_reader_if #(
  parameter int ACC_W = 40
);
  logic             n_empty;
  logic [63:0]      Dout;
  logic             RE;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             busy;

  modport slave (
    input  n_empty, Dout, out_ready,
    output RE, acc_out, out_valid, ovf, busy
  );

  modport master (
    output n_empty, Dout, out_ready,
    input  RE, acc_out, out_valid, ovf, busy
  );
endinterface

// File: rtl/fifo_mac_reader.sv
// fifo_mac_reader: pops 64-bit FIFO words, accumulates L0*L1+L2*L3 per block.
// Ports: clk_out, rst_n (sync, active-low), bus (fifo_mac_reader_if.slave).
module fifo_mac_reader #(
  parameter int BLOCK_LEN = 8,
  parameter int ACC_W     = 40
) (
  input  logic             clk_out,
  input  logic             rst_n,
  fifo_mac_reader_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [7:0] LEN  = 8'(BLOCK_LEN);
  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [7:0] r_issued;
  logic [7:0] w_issued_nx;

  logic r_v0;
  logic r_v1;
  logic r_v2;

  logic [63:0]        r_d1;
  logic signed [31:0] r_p0;
  logic signed [31:0] r_p1;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nx;
  logic                    r_ovf;
  logic                    w_ovf_nx;

  logic w_re;
  logic w_last;
  logic w_done;
  logic w_accept;

  logic signed [15:0] w_l0;
  logic signed [15:0] w_l1;
  logic signed [15:0] w_l2;
  logic signed [15:0] w_l3;

  logic signed [32:0]      w_word;
  logic signed [ACC_W-1:0] w_wext;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_add_ovf;

  assign w_re = rst_n & bus.n_empty
              & (r_state == RUN)
              & (r_issued < LEN);

  assign w_last   = w_re & (r_issued == LAST);
  // No reads happen in DRAIN, so the pipe is empty
  // once the oldest stage holds the only word left.
  assign w_done   = r_v2 & ~r_v1 & ~r_v0;
  assign w_accept = (r_state == OUT) & bus.out_ready;

  assign w_l0 = r_d1[15:0];
  assign w_l1 = r_d1[31:16];
  assign w_l2 = r_d1[47:32];
  assign w_l3 = r_d1[63:48];

  assign w_word = 33'(r_p0) + 33'(r_p1);
  assign w_wext = ACC_W'(w_word);
  assign w_sum  = r_acc + w_wext;

  assign w_add_ovf =
    (r_acc[ACC_W-1] == w_wext[ACC_W-1]) &
    (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_comb begin
    w_state_nx  = r_state;
    w_issued_nx = r_issued;
    unique case (r_state)
      RUN: begin
        if (w_re)   w_issued_nx = r_issued + 8'd1;
        if (w_last) w_state_nx  = DRAIN;
      end
      DRAIN: begin
        if (w_done) w_state_nx = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          w_state_nx  = RUN;
          w_issued_nx = '0;
        end
      end
      default: w_state_nx = RUN;
    endcase
  end

  always_comb begin
    w_acc_nx = r_acc;
    w_ovf_nx = r_ovf;
    if (w_accept) begin
      w_acc_nx = '0;
      w_ovf_nx = 1'b0;
    end else if (r_v2) begin
      w_acc_nx = w_sum;
      w_ovf_nx = r_ovf | w_add_ovf;
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_issued <= '0;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_issued <= w_issued_nx;
      r_v0     <= w_re;
      r_v1     <= r_v0;
      r_v2     <= r_v1;
      r_acc    <= w_acc_nx;
      r_ovf    <= w_ovf_nx;
    end
  end

  // Data stages are qualified by the valid bits,
  // so they need no reset.
  always_ff @(posedge clk_out) begin
    if (r_v0) r_d1 <= bus.Dout;
    if (r_v1) begin
      r_p0 <= 32'(w_l0) * 32'(w_l1);
      r_p1 <= 32'(w_l2) * 32'(w_l3);
    end
  end

  assign bus.RE        = w_re;
  assign bus.acc_out   = r_acc;
  assign bus.out_valid = (r_state == OUT);
  assign bus.ovf       = r_ovf;
  assign bus.busy      = rst_n & (r_state != OUT);

endmodule

// File: tb/tb_fifo_mac_reader.sv
// tb_fifo_mac_reader: FIFO model plus sum/overflow reference model.
// Two DUTs (ACC_W=40 and ACC_W=34) share identical stimulus.
module tb_fifo_mac_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        n_empty = 1'b0;
  logic [63:0] dout = '0;
  logic        out_ready = 1'b0;

  fifo_mac_reader_if #(.ACC_W(40)) bus_a ();
  fifo_mac_reader_if #(.ACC_W(34)) bus_b ();

  assign bus_a.n_empty   = n_empty;
  assign bus_a.Dout      = dout;
  assign bus_a.out_ready = out_ready;
  assign bus_b.n_empty   = n_empty;
  assign bus_b.Dout      = dout;
  assign bus_b.out_ready = out_ready;

  fifo_mac_reader #(.BLOCK_LEN(8), .ACC_W(40)) dut_a (
    .clk_out (clk),
    .rst_n   (rst_n),
    .bus     (bus_a.slave)
  );

  fifo_mac_reader #(.BLOCK_LEN(8), .ACC_W(34)) dut_b (
    .clk_out (clk),
    .rst_n   (rst_n),
    .bus     (bus_b.slave)
  );

  logic [63:0] fifo_q[$];
  bit gate = 1'b0;
  int cyc = 0;
  int re_cnt, re_bad, first_re, last_re;
  int total = 0;
  int passed = 0;

  function automatic logic [63:0] mk(
    input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic longint wval(input logic [63:0] w);
    longint l0, l1, l2, l3;
    l0 = longint'($signed(w[15:0]));
    l1 = longint'($signed(w[31:16]));
    l2 = longint'($signed(w[47:32]));
    l3 = longint'($signed(w[63:48]));
    return l0 * l1 + l2 * l3;
  endfunction

  // True running sum, folded back into the ACC_W signed
  // range whenever it leaves it (which is an overflow).
  function automatic void model(
    input  logic [63:0] ws[$],
    input  int          accw,
    output longint      res,
    output bit          ov);
    longint half, a;
    half = longint'(1) << (accw - 1);
    a = 0;
    ov = 1'b0;
    foreach (ws[i]) begin
      a = a + wval(ws[i]);
      if (a >= half) begin
        a = a - 2 * half;
        ov = 1'b1;
      end else if (a < -half) begin
        a = a + 2 * half;
        ov = 1'b1;
      end
    end
    res = a;
  endfunction

  task automatic clr_stats();
    re_cnt = 0;
    re_bad = 0;
    first_re = -1;
    last_re = -1;
  endtask

  // One clock cycle: present n_empty, record RE,
  // then model the FIFO pop at the edge.
  task automatic step();
    bit re_now;
    n_empty = gate && (fifo_q.size() != 0);
    #1;
    re_now = bus_a.RE;
    if (re_now) begin
      re_cnt++;
      last_re = cyc;
      if (first_re < 0) first_re = cyc;
      if (!n_empty) re_bad++;
    end
    @(posedge clk);
    #1;
    if (re_now && fifo_q.size() != 0)
      dout = fifo_q.pop_front();
    #1;
    cyc++;
  endtask

  task automatic wait_valid(output int vc, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    while (bus_a.out_valid !== 1'b1) begin
      if (n == 200) begin
        to = 1'b1;
        break;
      end
      step();
      n++;
    end
    vc = cyc;
  endtask

  task automatic push_block(input logic [63:0] ws[$]);
    foreach (ws[i]) fifo_q.push_back(ws[i]);
  endtask

  task automatic test_reset();
    gate = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++)
      fifo_q.push_back(mk(16'd1, 16'd1, 16'd1, 16'd1));
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus_a.RE !== 1'b0)
        $display("FAIL rst_re: got %0b want 0", bus_a.RE);
      else passed++;
      total++;
      if (bus_a.out_valid !== 1'b0)
        $display("FAIL rst_valid: got %0b want 0", bus_a.out_valid);
      else passed++;
      total++;
      if (bus_a.acc_out !== 40'd0 || bus_a.ovf !== 1'b0)
        $display("FAIL rst_acc: got %0d/%0b want 0/0",
                 bus_a.acc_out, bus_a.ovf);
      else passed++;
      total++;
      if (bus_a.busy !== 1'b0)
        $display("FAIL rst_busy: got %0b want 0", bus_a.busy);
      else passed++;
    end
    fifo_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] ws[$];
    longint ea;
    bit eo, to;
    int vc;
    for (int i = 0; i < 8; i++)
      ws.push_back(mk(16'd2, 16'd2, 16'd2, 16'd2));
    model(ws, 40, ea, eo);
    push_block(ws);
    clr_stats();
    gate = 1'b1;
    out_ready = 1'b1;
    step();
    total++;
    if (bus_a.busy !== 1'b1)
      $display("FAIL basic_busy_run: got %0b want 1", bus_a.busy);
    else passed++;
    wait_valid(vc, to);
    total++;
    if (to) $display("FAIL basic_timeout: got none want out_valid");
    else passed++;
    total++;
    if (re_cnt != 8 || last_re - first_re != 7)
      $display("FAIL basic_re: got %0d span %0d want 8 span 7",
               re_cnt, last_re - first_re);
    else passed++;
    total++;
    if (vc - first_re != 11)
      $display("FAIL basic_latency: got %0d want 11", vc - first_re);
    else passed++;
    total++;
    if (bus_a.acc_out !== 40'(ea) || ea != 64)
      $display("FAIL basic_acc: got %0d want 64", bus_a.acc_out);
    else passed++;
    total++;
    if (bus_a.ovf !== eo || bus_a.busy !== 1'b0)
      $display("FAIL basic_ovf_busy: got %0b/%0b want %0b/0",
               bus_a.ovf, bus_a.busy, eo);
    else passed++;
    step();
    total++;
    if (bus_a.out_valid !== 1'b0)
      $display("FAIL basic_accept: got %0b want 0", bus_a.out_valid);
    else passed++;
  endtask

  task automatic test_signed();
    logic [63:0] ws[$];
    longint ea, eb;
    bit eoa, eob, to;
    int vc;
    for (int i = 0; i < 8; i++)
      ws.push_back(mk(16'h8000, 16'h8000, 16'h8000, 16'h8000));
    model(ws, 40, ea, eoa);
    model(ws, 34, eb, eob);
    push_block(ws);
    clr_stats();
    wait_valid(vc, to);
    total++;
    if (to || bus_b.out_valid !== 1'b1)
      $display("FAIL sgn_valid: got %0b want 1", bus_b.out_valid);
    else passed++;
    total++;
    if (bus_a.acc_out !== 40'(ea) || ea != 64'h4_0000_0000)
      $display("FAIL sgn_acc40: got %0h want 400000000", bus_a.acc_out);
    else passed++;
    total++;
    if (bus_a.ovf !== 1'b0 || eoa)
      $display("FAIL sgn_ovf40: got %0b want 0", bus_a.ovf);
    else passed++;
    total++;
    if (bus_b.acc_out !== 34'(eb) || eb != 0)
      $display("FAIL sgn_acc34: got %0h want 0", bus_b.acc_out);
    else passed++;
    total++;
    if (bus_b.ovf !== 1'b1 || !eob)
      $display("FAIL sgn_ovf34: got %0b want 1", bus_b.ovf);
    else passed++;
    step();
  endtask

  task automatic test_gapped();
    logic [63:0] ws[$];
    longint ea;
    bit eo;
    int k;
    for (int i = 0; i < 8; i++)
      ws.push_back(mk(-16'sd3, 16'sd5, 16'sd7, -16'sd2));
    model(ws, 40, ea, eo);
    push_block(ws);
    clr_stats();
    k = 0;
    while (bus_a.out_valid !== 1'b1 && k < 200) begin
      gate = (k % 4 == 0) || (k % 4 == 3);
      step();
      k++;
    end
    gate = 1'b1;
    total++;
    if (re_cnt != 8 || re_bad != 0)
      $display("FAIL gap_re: got %0d bad %0d want 8 bad 0",
               re_cnt, re_bad);
    else passed++;
    total++;
    if (bus_a.acc_out !== 40'(ea) || ea != -232)
      $display("FAIL gap_acc: got %0d want -232",
               $signed(bus_a.acc_out));
    else passed++;
    total++;
    if (cyc != last_re + 4)
      $display("FAIL gap_latency: got %0d want %0d", cyc, last_re + 4);
    else passed++;
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] wa[$], wb[$];
    logic [39:0] hold;
    longint ea, eb;
    bit eo, to;
    int vc, rc;
    for (int i = 0; i < 8; i++) begin
      wa.push_back(mk(16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom)));
      wb.push_back(mk(16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom)));
    end
    push_block(wa);
    push_block(wb);
    clr_stats();
    out_ready = 1'b0;
    wait_valid(vc, to);
    model(wa, 40, ea, eo);
    hold = bus_a.acc_out;
    total++;
    if (to || hold !== 40'(ea))
      $display("FAIL bp_acc_a: got %0h want %0h", hold, 40'(ea));
    else passed++;
    rc = re_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (re_cnt != rc || bus_a.RE !== 1'b0)
        $display("FAIL bp_re: got %0d want %0d", re_cnt, rc);
      else passed++;
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== hold)
        $display("FAIL bp_hold: got %0h want %0h", bus_a.acc_out, hold);
      else passed++;
    end
    out_ready = 1'b1;
    step();
    total++;
    if (bus_a.RE !== 1'b1 || bus_a.out_valid !== 1'b0)
      $display("FAIL bp_resume: got re %0b want 1", bus_a.RE);
    else passed++;
    clr_stats();
    wait_valid(vc, to);
    model(wb, 40, eb, eo);
    total++;
    if (to || bus_a.acc_out !== 40'(eb) || bus_a.ovf !== eo)
      $display("FAIL bp_acc_b: got %0h want %0h",
               bus_a.acc_out, 40'(eb));
    else passed++;
    step();
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      logic [63:0] ws[$];
      logic [15:0] ln[4];
      longint ea, eb;
      bit eoa, eob;
      int k, d;
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 4; j++)
          ln[j] = (b % 2 == 1) ?
                  (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7fff) :
                  16'($urandom);
        ws.push_back(mk(ln[0], ln[1], ln[2], ln[3]));
      end
      model(ws, 40, ea, eoa);
      model(ws, 34, eb, eob);
      push_block(ws);
      clr_stats();
      out_ready = 1'b0;
      k = 0;
      while (bus_a.out_valid !== 1'b1 && k < 300) begin
        gate = ($urandom_range(0, 3) != 0);
        step();
        k++;
      end
      gate = 1'b1;
      total++;
      if (re_cnt != 8 || re_bad != 0 || cyc != last_re + 4)
        $display("FAIL rnd_flow: got %0d/%0d/%0d want 8/0/%0d",
                 re_cnt, re_bad, cyc, last_re + 4);
      else passed++;
      total++;
      if (bus_a.acc_out !== 40'(ea) || bus_a.ovf !== eoa)
        $display("FAIL rnd_a: got %0h/%0b want %0h/%0b",
                 bus_a.acc_out, bus_a.ovf, 40'(ea), eoa);
      else passed++;
      total++;
      if (bus_b.acc_out !== 34'(eb) || bus_b.ovf !== eob)
        $display("FAIL rnd_b: got %0h/%0b want %0h/%0b",
                 bus_b.acc_out, bus_b.ovf, 34'(eb), eob);
      else passed++;
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) step();
      out_ready = 1'b1;
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] ws[$];
    longint ea;
    bit eo, to;
    int vc, k;
    for (int i = 0; i < 6; i++)
      fifo_q.push_back(mk(16'($urandom), 16'd1000, 16'd999, 16'd7));
    clr_stats();
    gate = 1'b1;
    k = 0;
    while (re_cnt < 3 && k < 50) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    step();
    total++;
    if (re_cnt != 3)
      $display("FAIL mrst_re: got %0d want 3", re_cnt);
    else passed++;
    rst_n = 1'b1;
    fifo_q.delete();
    for (int i = 0; i < 8; i++)
      ws.push_back(mk(16'd2, 16'd2, 16'd2, 16'd2));
    model(ws, 40, ea, eo);
    push_block(ws);
    clr_stats();
    wait_valid(vc, to);
    total++;
    if (to || bus_a.acc_out !== 40'(ea) || ea != 64)
      $display("FAIL mrst_acc: got %0d want 64", bus_a.acc_out);
    else passed++;
    total++;
    if (re_cnt != 8 || bus_a.ovf !== 1'b0)
      $display("FAIL mrst_cnt: got %0d/%0b want 8/0",
               re_cnt, bus_a.ovf);
    else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_gapped();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
